// File: rtl/rv_mem_arbiter_if.sv
// Fetch and data request/response bundle between the core and the shared memory arbiter.
interface rv_mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);

  // Instruction-fetch port (read-only)
  logic              i_req;
  logic [XLEN-1:0]   i_addr;
  logic              i_ready;
  logic [XLEN-1:0]   i_rdata;

  // Data port (read/write with byte enables)
  logic              d_req;
  logic              d_we;
  logic [XLEN/8-1:0] d_be;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic              d_ready;
  logic [XLEN-1:0]   d_rdata;

  // Requester side (the core)
  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  i_ready, i_rdata, d_ready, d_rdata
  );

  // Memory side (the arbiter)
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output i_ready, i_rdata, d_ready, d_rdata
  );

endinterface

// File: rtl/rv_mem_arbiter.sv
// Shared single-port word memory serving a fetch port and a data port with a
// req/ready handshake, programmable wait states and data-priority arbitration
// bounded by a fetch starvation limit.
module rv_mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned WAIT_STATES  = 2,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  rv_mem_arbiter_if.slave         bus,
  output logic                    busy
);

  localparam int unsigned BeW     = XLEN / 8;
  localparam int unsigned OffW    = $clog2(BeW);
  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                gnt_i_q, gnt_i_d;  // 1: fetch port owns the transaction
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                we_q, we_d;
  logic [BeW-1:0]      be_q, be_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     i_rdata_q, d_rdata_q;

  logic [XLEN-1:0]     mem [DEPTH_WORDS];

  logic                fetch_forced, grant_i, grant_any;
  logic [XLEN-1:0]     live_addr;
  logic                go_access;
  logic                acc_i, acc_we;
  logic [IdxW-1:0]     acc_idx;
  logic [BeW-1:0]      acc_be;
  logic [XLEN-1:0]     acc_wdata;
  logic                unused_addr;

  // Arbitration: data wins unless the fetch has waited STARVE_LIMIT data grants.
  always_comb begin
    fetch_forced = bus.i_req && (starve_q == StarveW'(STARVE_LIMIT));
    grant_i      = bus.i_req && (!bus.d_req || fetch_forced);
    grant_any    = bus.i_req || bus.d_req;
    live_addr    = grant_i ? bus.i_addr : bus.d_addr;
  end

  // Offset bits and bits above the array size are deliberately dropped.
  assign unused_addr = ^{live_addr[XLEN-1:IdxW+OffW], live_addr[OffW-1:0]};

  // Next-state logic: latch the winning request in IDLE, count waits, then access.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    gnt_i_d   = gnt_i_q;
    idx_d     = idx_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    go_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          gnt_i_d = grant_i;
          idx_d   = live_addr[IdxW+OffW-1:OffW];
          we_d    = !grant_i && bus.d_we;
          be_d    = bus.d_be;
          wdata_d = bus.d_wdata;
          wait_d  = 4'(WAIT_STATES);
          if (grant_i) begin
            starve_d = '0;
          end else if (bus.i_req) begin
            starve_d = starve_q + StarveW'(1);
          end
          if (WAIT_STATES == 0) begin
            state_d   = StAccess;
            go_access = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d   = StAccess;
          go_access = 1'b1;
        end
      end
      StAccess: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // With zero wait states the access edge is the grant edge, so use live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_i     = grant_i;
      acc_we    = !grant_i && bus.d_we;
      acc_idx   = live_addr[IdxW+OffW-1:OffW];
      acc_be    = bus.d_be;
      acc_wdata = bus.d_wdata;
    end else begin
      acc_i     = gnt_i_q;
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_be    = be_q;
      acc_wdata = wdata_q;
    end
  end

  // Control and request-latch registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      starve_q <= '0;
      gnt_i_q  <= 1'b0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      gnt_i_q  <= gnt_i_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  // Read data is captured on the edge entering ACCESS so it is valid with ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (go_access) begin
      if (acc_i) begin
        i_rdata_q <= mem[acc_idx];
      end else begin
        d_rdata_q <= mem[acc_idx];
      end
    end
  end

  // Array write on the same edge as the read, so writes return pre-write data.
  always_ff @(posedge clk) begin
    if (go_access && reset && acc_we) begin
      for (int k = 0; k < BeW; k++) begin
        if (acc_be[k]) begin
          mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
        end
      end
    end
  end

  assign bus.i_ready = (state_q == StAccess) && gnt_i_q;
  assign bus.d_ready = (state_q == StAccess) && !gnt_i_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench: one instance with 2 wait states, one with 0 wait states.
module tb_rv_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst0, busy2, busy0;
  int   total = 0;
  int   bad   = 0;

  rv_mem_arbiter_if #(.XLEN(32)) bus2 ();
  rv_mem_arbiter_if #(.XLEN(32)) bus0 ();

  rv_mem_arbiter #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2), .STARVE_LIMIT(2)) u_dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2),
    .busy  (busy2)
  );

  rv_mem_arbiter #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0), .STARVE_LIMIT(2)) u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0),
    .busy  (busy0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_xact2(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output bit ok);
    bus2.d_req = 1'b1; bus2.d_we = we; bus2.d_be = be; bus2.d_addr = addr; bus2.d_wdata = wdata;
    ok = 1'b0; rdata = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      if (bus2.d_ready) begin ok = 1'b1; rdata = bus2.d_rdata; end
    end
    bus2.d_req = 1'b0;
  endtask

  task automatic i_xact2(input logic [31:0] addr, output logic [31:0] rdata, output bit ok);
    bus2.i_req = 1'b1; bus2.i_addr = addr;
    ok = 1'b0; rdata = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      if (bus2.i_ready) begin ok = 1'b1; rdata = bus2.i_rdata; end
    end
    bus2.i_req = 1'b0;
  endtask

  task automatic d_xact0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output bit ok);
    bus0.d_req = 1'b1; bus0.d_we = we; bus0.d_be = be; bus0.d_addr = addr; bus0.d_wdata = wdata;
    ok = 1'b0; rdata = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      if (bus0.d_ready) begin ok = 1'b1; rdata = bus0.d_rdata; end
    end
    bus0.d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst2 = 1'b0; rst0 = 1'b0;
    bus2.i_req = 0; bus2.i_addr = 0; bus2.d_req = 0; bus2.d_we = 0; bus2.d_be = 0;
    bus2.d_addr = 0; bus2.d_wdata = 0;
    bus0.i_req = 0; bus0.i_addr = 0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_be = 0;
    bus0.d_addr = 0; bus0.d_wdata = 0;
    #2;
    total++; if (bus2.i_ready !== 1'b0) begin bad++; $display("FAIL rst_i_ready got %b want 0", bus2.i_ready); end
    total++; if (bus2.d_ready !== 1'b0) begin bad++; $display("FAIL rst_d_ready got %b want 0", bus2.d_ready); end
    total++; if (bus2.i_rdata !== 32'h0) begin bad++; $display("FAIL rst_i_rdata got %h want 0", bus2.i_rdata); end
    total++; if (bus2.d_rdata !== 32'h0) begin bad++; $display("FAIL rst_d_rdata got %h want 0", bus2.d_rdata); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy2); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy0 got %b want 0", busy0); end
    repeat (3) tick();
    rst2 = 1'b1; rst0 = 1'b1;
    tick();
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL post_rst_busy got %b want 0", busy2); end
  endtask

  task automatic preload();
    logic [31:0] rd; bit ok;
    d_xact2(1'b1, 4'hF, 32'h8, 32'hDEADBEEF, rd, ok);
    total++; if (!ok) begin bad++; $display("FAIL preload8 got no_ready want ready"); end
    d_xact2(1'b1, 4'hF, 32'h40, 32'hAABBCCDD, rd, ok);
    total++; if (!ok) begin bad++; $display("FAIL preload40 got no_ready want ready"); end
  endtask

  task automatic test_fetch_latency();
    logic exp_rdy, exp_busy;
    tick();
    bus2.i_req = 1'b1; bus2.i_addr = 32'h8;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_rdy  = (k == 3);
      exp_busy = (k <= 3);
      total++; if (bus2.i_ready !== exp_rdy) begin bad++; $display("FAIL lat_i_ready[%0d] got %b want %b", k, bus2.i_ready, exp_rdy); end
      total++; if (busy2 !== exp_busy) begin bad++; $display("FAIL lat_busy[%0d] got %b want %b", k, busy2, exp_busy); end
      total++; if (bus2.d_ready !== 1'b0) begin bad++; $display("FAIL lat_d_ready[%0d] got %b want 0", k, bus2.d_ready); end
      if (k == 3) begin
        total++; if (bus2.i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lat_i_rdata got %h want deadbeef", bus2.i_rdata); end
        bus2.i_req = 1'b0;
      end
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; bit ok;
    tick();
    d_xact2(1'b1, 4'b0101, 32'h40, 32'h11223344, rd, ok);
    total++; if (!ok || rd !== 32'hAABBCCDD) begin bad++; $display("FAIL bw_prewrite got %h ok=%0d want aabbccdd", rd, ok); end
    d_xact2(1'b0, 4'h0, 32'h40, 32'h0, rd, ok);
    total++; if (!ok || rd !== 32'hAA22CC44) begin bad++; $display("FAIL bw_readback got %h ok=%0d want aa22cc44", rd, ok); end
  endtask

  task automatic test_be_zero();
    logic [31:0] rd; bit ok;
    d_xact2(1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, rd, ok);
    total++; if (!ok) begin bad++; $display("FAIL be0_ready got no_ready want ready"); end
    d_xact2(1'b0, 4'h0, 32'h40, 32'h0, rd, ok);
    total++; if (!ok || rd !== 32'hAA22CC44) begin bad++; $display("FAIL be0_readback got %h ok=%0d want aa22cc44", rd, ok); end
  endtask

  task automatic test_starve();
    bit exp_i [6];
    int wait_n, exp_wait;
    bit got;
    logic [1:0] exp_rdy;
    exp_i = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tick();
    bus2.i_req = 1'b1; bus2.i_addr = 32'h8;
    bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_be = 4'h0; bus2.d_addr = 32'h40;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0; wait_n = 0;
      while (!got && wait_n < 10) begin
        tick(); wait_n++;
        if (bus2.i_ready || bus2.d_ready) got = 1'b1;
      end
      exp_rdy  = exp_i[g] ? 2'b10 : 2'b01;
      exp_wait = (g == 0) ? 3 : 4;
      total++; if ({bus2.i_ready, bus2.d_ready} !== exp_rdy) begin bad++; $display("FAIL starve_grant[%0d] got %b want %b", g, {bus2.i_ready, bus2.d_ready}, exp_rdy); end
      total++; if (wait_n != exp_wait) begin bad++; $display("FAIL starve_spacing[%0d] got %0d want %0d", g, wait_n, exp_wait); end
      if (exp_i[g]) begin
        total++; if (bus2.i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL starve_i_rdata[%0d] got %h want deadbeef", g, bus2.i_rdata); end
      end else begin
        total++; if (bus2.d_rdata !== 32'hAA22CC44) begin bad++; $display("FAIL starve_d_rdata[%0d] got %h want aa22cc44", g, bus2.d_rdata); end
      end
    end
    bus2.i_req = 1'b0; bus2.d_req = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    logic [31:0] rd; bit ok;
    d_xact2(1'b1, 4'hF, 32'h1000, 32'h5A5A1234, rd, ok);
    total++; if (!ok) begin bad++; $display("FAIL alias_write got no_ready want ready"); end
    i_xact2(32'h0, rd, ok);
    total++; if (!ok || rd !== 32'h5A5A1234) begin bad++; $display("FAIL alias_fetch0 got %h ok=%0d want 5a5a1234", rd, ok); end
    d_xact2(1'b0, 4'h0, 32'h0, 32'h0, rd, ok);
    total++; if (!ok || rd !== 32'h5A5A1234) begin bad++; $display("FAIL alias_read0 got %h ok=%0d want 5a5a1234", rd, ok); end
  endtask

  task automatic test_req_drop();
    logic [31:0] rd; bit ok, got; int wait_n;
    tick();
    bus2.d_req = 1'b1; bus2.d_we = 1'b1; bus2.d_be = 4'hF;
    bus2.d_addr = 32'h80; bus2.d_wdata = 32'h0BADF00D;
    tick();
    bus2.d_req = 1'b0; bus2.d_wdata = 32'hFFFFFFFF; bus2.d_addr = 32'h84; bus2.d_we = 1'b0;
    got = 1'b0; wait_n = 0;
    while (!got && wait_n < 10) begin
      tick(); wait_n++;
      if (bus2.d_ready) got = 1'b1;
    end
    total++; if (!got || wait_n != 2) begin bad++; $display("FAIL drop_ready got wait=%0d seen=%0d want wait=2", wait_n, got); end
    d_xact2(1'b0, 4'h0, 32'h80, 32'h0, rd, ok);
    total++; if (!ok || rd !== 32'h0BADF00D) begin bad++; $display("FAIL drop_commit got %h ok=%0d want 0badf00d", rd, ok); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; bit ok;
    tick();
    bus2.d_req = 1'b1; bus2.d_we = 1'b1; bus2.d_be = 4'hF;
    bus2.d_addr = 32'h40; bus2.d_wdata = 32'h99999999;
    tick();
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL rw_busy_before got %b want 1", busy2); end
    #3 rst2 = 1'b0;
    #1;
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rw_busy got %b want 0", busy2); end
    total++; if (bus2.d_rdata !== 32'h0) begin bad++; $display("FAIL rw_d_rdata got %h want 0", bus2.d_rdata); end
    total++; if (bus2.i_rdata !== 32'h0) begin bad++; $display("FAIL rw_i_rdata got %h want 0", bus2.i_rdata); end
    total++; if (bus2.d_ready !== 1'b0) begin bad++; $display("FAIL rw_d_ready got %b want 0", bus2.d_ready); end
    bus2.d_req = 1'b0;
    repeat (2) tick();
    rst2 = 1'b1;
    tick();
    d_xact2(1'b0, 4'h0, 32'h40, 32'h0, rd, ok);
    total++; if (!ok || rd !== 32'hAA22CC44) begin bad++; $display("FAIL rw_no_commit got %h ok=%0d want aa22cc44", rd, ok); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [31:0] rd; bit ok;
    logic exp_rdy;
    int idx;
    vals = '{32'h01020304, 32'hCAFEF00D, 32'h00FF00FF, 32'h76543210};
    for (int i = 0; i < 4; i++) begin
      d_xact0(1'b1, 4'hF, 32'(i * 4), vals[i], rd, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_preload[%0d] got no_ready want ready", i); end
    end
    tick();
    idx = 0;
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_be = 4'h0; bus0.d_addr = 32'h0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_rdy = (e % 2 == 1);
      total++; if (bus0.d_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready[%0d] got %b want %b", e, bus0.d_ready, exp_rdy); end
      if (bus0.d_ready && idx < 4) begin
        total++; if (bus0.d_rdata !== vals[idx]) begin bad++; $display("FAIL b2b_rdata[%0d] got %h want %h", idx, bus0.d_rdata, vals[idx]); end
        idx++;
        bus0.d_addr = 32'(idx * 4);
        if (idx == 4) bus0.d_req = 1'b0;
      end
    end
    total++; if (idx != 4) begin bad++; $display("FAIL b2b_count got %0d want 4", idx); end
  endtask

  initial begin
    test_reset();
    preload();
    test_fetch_latency();
    test_byte_write();
    test_be_zero();
    test_starve();
    test_alias();
    test_req_drop();
    test_reset_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
